// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice and a carry flop process the
// operands LSB first, producing a registered sum/carry with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH:0]   rs_ext;

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    s_bit  = ra_q[0] ^ rb_q[0] ^ c_q;
    c_next = (ra_q[0] & rb_q[0]) | (c_q & (ra_q[0] ^ rb_q[0]));
    // New bit enters at the MSB; the concatenation keeps the slice legal for WIDTH=1.
    rs_ext = {s_bit, rs_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          rs_d    = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        c_d   = c_next;
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        rs_d  = rs_ext[WIDTH:1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_d   = rs_ext[WIDTH:1];
          cout_d  = c_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder and the additive counterpart of the team's half/full subtractor cells. It takes two WIDTH-bit operands and a carry-in on a start pulse. It adds one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop. It presents a registered sum and carry-out with a one-cycle done pulse. It sits beside the subtractor datapath where area matters more than latency.

## Interface

- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  output  WIDTH  registered result, a + b + cin mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation

- States: IDLE, SHIFT, DONE. Encoding is free. Reset state is IDLE.
- Internal registers:
  - shift registers ra and rb (WIDTH each);
  - accumulator rs (WIDTH);
  - carry flip-flop c;
  - bit counter cnt (clog2(WIDTH+1) bits).
- IDLE, start=1:
  - ra<=a, rb<=b, c<=cin, cnt<=0, rs<=0;
  - go to SHIFT.
- IDLE, start=0: hold.
- SHIFT, each edge:
  - s = ra[0]^rb[0]^c;
  - c <= (ra[0]&rb[0]) | (c&(ra[0]^rb[0]));
  - ra, rb shift right one bit, zero-filled;
  - rs shifts right one bit with s inserted at bit WIDTH-1;
  - cnt <= cnt+1.
- SHIFT, on the edge where cnt==WIDTH-1 (final bit):
  - sum <= final rs value, including this cycle's s;
  - cout <= new carry;
  - go to DONE.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- sum and cout change only on the edge entering DONE. They hold their value through IDLE and through the next operation's SHIFT cycles until the next completion.
- start is ignored in SHIFT and in DONE. It has no effect and is not queued.
- a, b, cin are don't-care except on the accepting edge. Changing them during SHIFT has no effect.
- WIDTH=1: SHIFT lasts one cycle and behaves as a single registered full adder.

## Timing

- Reset values (asynchronous, immediate on rst rising):
  - busy=0, done=0, sum=0, cout=0;
  - state IDLE;
  - all internal registers 0.
- busy is high exactly when state==SHIFT. done is high exactly when state==DONE. Both are decoded from registered state.
- Let E0 be the edge that samples start=1 in IDLE:
  - busy=1 after E0 through EWIDTH, i.e. WIDTH cycles;
  - done=1 and new sum/cout valid after EWIDTH, for one cycle;
  - state returns to IDLE after E(WIDTH+1).
- Latency from accepting edge to done: WIDTH+1 cycles in total (WIDTH busy cycles, then the done cycle). Minimum start-to-start spacing is WIDTH+2 edges.
- busy and done are never high together.
- rst asserted mid-operation:
  - aborts immediately and clears sum/cout to 0;
  - no done pulse for the aborted operation.
- start may be held high continuously. Each IDLE visit then accepts a new operation, giving back-to-back results every WIDTH+2 cycles.

## Test plan

- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, single start pulse. Required: busy high for 8 cycles; done pulse on the 9th cycle; sum=0x96, cout=0.
- Carry chain and wrap-around: a=0xFF, b=0x01, cin=0. Required: sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1. Required: sum=0xFF, cout=1.
- Start while busy: start a=0x10, b=0x20; pulse start again at cycle 3 with a=0xAA, b=0x55. Required: one done only, sum=0x30; second request ignored; operand changes during SHIFT do not alter the result.
- Reset mid-operation: after a completed op leaves sum=0x96, start a=0x01, b=0x01; assert rst at cycle 4. Required: sum=0, cout=0, busy=0, done=0 immediately; no done pulse afterwards. A subsequent op 0x01+0x01 yields 0x02.
- Output hold and back-to-back: hold start=1 with a=0x80, b=0x80, cin=0. Required: sum=0x00, cout=1 at each done; done pulses spaced WIDTH+2 cycles apart; sum stays stable between completions.
- WIDTH=1 instance: exhaustive over all 8 combinations of (a, b, cin). Required: sum/cout match a full adder; done one cycle after busy.
